// File: rtl/bin_weight_loader_pkg.sv
// Shared types and sizing helpers for the binary-weight loader and the layer it feeds.
package bin_weight_loader_pkg;

    localparam int DEF_INPUT_DIM  = 16;
    localparam int DEF_OUTPUT_DIM = 4;
    localparam int DEF_WORD_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    // Row-major weight matrix; row 0 occupies the least-significant INPUT_DIM bits.
    typedef logic [DEF_OUTPUT_DIM-1:0][DEF_INPUT_DIM-1:0] weight_mat_t;

    function automatic int calc_wpr(input int input_dim, input int word_w);
        return input_dim / word_w;
    endfunction

    function automatic int calc_beats(input int input_dim, input int output_dim, input int word_w);
        return (output_dim * input_dim) / word_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin_weight_loader_if.sv
// Stream-in / weight-out bundle between a weight source and the loader.
interface bin_weight_loader_if #(
    parameter int INPUT_DIM  = 16,
    parameter int OUTPUT_DIM = 4,
    parameter int WORD_W     = 8
);
    logic                                   start;
    logic                                   s_valid;
    logic                                   s_ready;
    logic [WORD_W-1:0]                      s_data;
    logic                                   s_last;
    logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]   weight;
    logic                                   weight_valid;
    logic                                   busy;
    logic                                   commit;
    logic                                   err;

    modport master (
        output start, s_valid, s_data, s_last,
        input  s_ready, weight, weight_valid, busy, commit, err
    );

    modport slave (
        input  start, s_valid, s_data, s_last,
        output s_ready, weight, weight_valid, busy, commit, err
    );

endinterface

// File: rtl/bin_weight_addr_ctr.sv
// Row/word write pointer into the shadow bank, with a flag for the terminal beat.
module bin_weight_addr_ctr
    import bin_weight_loader_pkg::*;
#(
    parameter int WPR        = 2,
    parameter int OUTPUT_DIM = 4,
    parameter int ROW_W      = idx_w(OUTPUT_DIM),
    parameter int WORD_CW    = idx_w(WPR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               inc,
    output logic [ROW_W-1:0]   row,
    output logic [WORD_CW-1:0] word,
    output logic               last_beat
);

    logic last_word;
    logic last_row;

    assign last_word = (word == WORD_CW'(WPR - 1));
    assign last_row  = (row == ROW_W'(OUTPUT_DIM - 1));
    assign last_beat = last_word && last_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            word <= '0;
        end else if (clear) begin
            row  <= '0;
            word <= '0;
        end else if (inc) begin
            if (last_word) begin
                word <= '0;
                row  <= last_row ? '0 : row + 1'b1;
            end else begin
                word <= word + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bin_weight_loader.sv
// Assembles streamed weight bits into a shadow bank and commits it atomically to the layer.
module bin_weight_loader
    import bin_weight_loader_pkg::*;
#(
    parameter int INPUT_DIM  = DEF_INPUT_DIM,
    parameter int OUTPUT_DIM = DEF_OUTPUT_DIM,
    parameter int WORD_W     = DEF_WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_weight_loader_if.slave   bus
);

    localparam int WPR     = calc_wpr(INPUT_DIM, WORD_W);
    localparam int ROW_W   = idx_w(OUTPUT_DIM);
    localparam int WORD_CW = idx_w(WPR);

    generate
        if ((INPUT_DIM % WORD_W) != 0) begin : g_bad_word_w
            $error("bin_weight_loader: INPUT_DIM must be a multiple of WORD_W");
        end
    endgenerate

    state_t                                state_q;
    state_t                                state_d;
    logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]  shadow_q;
    logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]  weight_q;
    logic                                  weight_valid_q;
    logic                                  commit_q;
    logic                                  err_q;

    logic                                  ctr_clear;
    logic                                  beat_acc;
    logic                                  err_set;
    logic                                  err_clr;
    logic                                  do_commit;
    logic [ROW_W-1:0]                      ctr_row;
    logic [WORD_CW-1:0]                    ctr_word;
    logic                                  last_beat;

    bin_weight_addr_ctr #(
        .WPR        (WPR),
        .OUTPUT_DIM (OUTPUT_DIM),
        .ROW_W      (ROW_W),
        .WORD_CW    (WORD_CW)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ctr_clear),
        .inc       (beat_acc),
        .row       (ctr_row),
        .word      (ctr_word),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start in LOAD wins over any beat presented in the same cycle.
    always_comb begin
        state_d   = state_q;
        ctr_clear = 1'b0;
        beat_acc  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ctr_clear = 1'b1;
                    err_clr   = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (bus.start) begin
                    ctr_clear = 1'b1;
                    err_clr   = 1'b1;
                end else if (bus.s_valid) begin
                    beat_acc = 1'b1;
                    if (last_beat) begin
                        err_set = !bus.s_last;
                        state_d = COMMIT;
                    end else if (bus.s_last) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q       <= '0;
            weight_q       <= '0;
            weight_valid_q <= 1'b0;
            commit_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (beat_acc) begin
                shadow_q[ctr_row][int'(ctr_word) * WORD_W +: WORD_W] <= bus.s_data;
            end
            if (do_commit) begin
                weight_q       <= shadow_q;
                weight_valid_q <= 1'b1;
            end
            commit_q <= do_commit;
            if (err_clr) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.s_ready      = (state_q == LOAD);
    assign bus.busy         = (state_q == LOAD) || (state_q == COMMIT);
    assign bus.weight       = weight_q;
    assign bus.weight_valid = weight_valid_q;
    assign bus.commit       = commit_q;
    assign bus.err          = err_q;

endmodule
